// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount frame arbiter: default sizing, word width
// and the controller state encoding.
// Pure declarations, no logic; imported by every file of the block.
// Purpose: single source of truth for constants used by the top and popcount7.
package popcount_pkg;

    localparam int NREQ_DEF  = 4;   // default number of requesters
    localparam int ACC_W_DEF = 16;  // default accumulator / result width
    localparam int WORD_W    = 7;   // width of one request beat
    localparam int CNT_W     = 3;   // width of a 7-bit set-bit count (0..7)

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/popcount7.sv
// Counts the set bits of one 7-bit beat.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input word.
// Ports: word_i - beat to count; cnt_o - number of ones (0..7).
module popcount7
    import popcount_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [CNT_W-1:0]  cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < WORD_W; i++) begin
            cnt_o = cnt_o + CNT_W'(word_i[i]);
        end
    end

endmodule

// File: rtl/popcount_frame_arbiter.sv
// Round-robin arbiter that grants one requester a whole frame and sums the set
// bits of its beats. Latency: grant one cycle after IDLE sees a request;
// result valid one cycle after the last beat. Backpressure: req_ready only for
// the owner in RUN; result held until res_ready; one IDLE cycle between frames.
// Ports: clk/rst_n; req_valid/req_data/req_last/req_ready per requester (7-bit
// words packed at [7k+6:7k]); res_valid/res_ready handshake with res_sum,
// res_id, res_sat (zero while res_valid is low); busy = not IDLE.
module popcount_frame_arbiter
    import popcount_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [WORD_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ACC_W-1:0]         res_sum,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic                     res_sat,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;

    logic [WORD_W-1:0]  word;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W:0]     sum_wide;
    logic               beat;

    // First requester with valid set, scanning upward from p and wrapping.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] sel;
        logic           found;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (int'(p) + i) % NREQ;
            if (!found && v[idx]) begin
                sel   = IDW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Only the owner's word reaches the single counter instance.
    always_comb begin
        word = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q == IDW'(k)) begin
                word = req_data[k*WORD_W +: WORD_W];
            end
        end
    end

    popcount7 u_popcount7 (
        .word_i (word),
        .cnt_o  (cnt)
    );

    assign req_ready = (state_q == ST_RUN) ? (NREQ'(1) << grant_q) : '0;
    assign beat      = (state_q == ST_RUN) && req_valid[grant_q];
    // One extra bit catches overflow so the accumulator can clamp.
    assign sum_wide  = {1'b0, acc_q} + (ACC_W+1)'(cnt);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_pick(req_valid, ptr_q);
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat) begin
                    if (sum_wide[ACC_W]) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum_wide[ACC_W-1:0];
                    end
                    if (req_last[grant_q]) begin
                        state_d = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                    ptr_d   = (grant_q == IDW'(NREQ-1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    assign res_valid = (state_q == ST_RESULT);
    assign res_sum   = res_valid ? acc_q   : '0;
    assign res_id    = res_valid ? grant_q : '0;
    assign res_sat   = res_valid ? sat_q   : 1'b0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_popcount_frame_arbiter.sv
module tb_popcount_frame_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [7*N-1:0]  req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic            res_ready = 1'b0;

    logic [N-1:0]    req_ready, req_ready_4;
    logic            res_valid, res_valid_4, res_sat, res_sat_4, busy, busy_4;
    logic [15:0]     res_sum;
    logic [3:0]      res_sum_4;
    logic [1:0]      res_id, res_id_4;

    int checks = 0;
    int errors = 0;

    // Frame stimulus per requester for the randomized scenario.
    logic [6:0] q_dat [N][$];
    logic       q_last[N][$];

    always #5 clk = ~clk;

    popcount_frame_arbiter #(.NREQ(N), .ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid),
        .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id),
        .res_sat(res_sat), .busy(busy));

    // Narrow-accumulator copy sharing all inputs, used for saturation checks.
    popcount_frame_arbiter #(.NREQ(N), .ACC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready_4), .res_valid(res_valid_4),
        .res_ready(res_ready), .res_sum(res_sum_4), .res_id(res_id_4),
        .res_sat(res_sat_4), .busy(busy_4));

    function automatic int rr_model(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return p;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present one beat on requester k until it is accepted (bounded wait).
    task automatic send_beat(input int k, input logic [6:0] w, input logic l);
        bit ok;
        ok = 0;
        req_valid[k] = 1'b1;
        req_data[k*7 +: 7] = w;
        req_last[k] = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept req%0d: req_ready=%b never set for it", k, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_last[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({req_ready, res_valid, res_sum, res_id, res_sat, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%0d id=%0d sat=%b busy=%b want all 0",
                     req_ready, res_valid, res_sum, res_id, res_sat, busy);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        apply_reset();
        send_beat(0, 7'h7F, 1'b0);
        send_beat(0, 7'h7F, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, res_valid, res_sum, res_id, res_sat, busy} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got rdy=%b vld=%b sum=%0d id=%0d sat=%b busy=%b want all 0",
                     req_ready, res_valid, res_sum, res_id, res_sat, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid || busy) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrun_no_result: got activity after release, want none");
        end
    endtask

    task automatic test_single_requester();
        apply_reset();
        res_ready = 1'b1;
        send_beat(2, 7'h7F, 1'b0);
        send_beat(2, 7'h01, 1'b0);
        send_beat(2, 7'h00, 1'b1);
        @(negedge clk);
        checks++;
        if ({res_valid, res_sum, res_id, res_sat} !== {1'b1, 16'd8, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL single_req_result: got vld=%b sum=%0d id=%0d sat=%b want 1/8/2/0",
                     res_valid, res_sum, res_id, res_sat);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int ids[$];
        int sums[$];
        logic [N-1:0] taken;
        apply_reset();
        res_ready = 1'b1;
        for (int k = 0; k < N; k++) req_data[k*7 +: 7] = 7'h03;
        req_valid = '1;
        req_last = '1;
        for (int c = 0; c < 80 && ids.size() < N; c++) begin
            @(negedge clk);
            taken = req_valid & req_ready;
            if (res_valid) begin
                ids.push_back(int'(res_id));
                sums.push_back(int'(res_sum));
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~taken;
        end
        checks++;
        if (ids.size() != N) begin
            errors++;
            $display("FAIL rr_count: got %0d results want %0d", ids.size(), N);
        end
        for (int i = 0; i < ids.size(); i++) begin
            checks++;
            if (ids[i] != i || sums[i] != 2) begin
                errors++;
                $display("FAIL rr_order[%0d]: got id=%0d sum=%0d want id=%0d sum=2", i, ids[i], sums[i], i);
            end
        end
        req_valid = '0;
        req_last = '0;
        res_ready = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        res_ready = 1'b1;
        send_beat(0, 7'h7F, 1'b0);
        send_beat(0, 7'h7F, 1'b0);
        send_beat(0, 7'h7F, 1'b1);
        @(negedge clk);
        checks++;
        if ({res_valid_4, res_sum_4, res_sat_4} !== {1'b1, 4'd15, 1'b1}) begin
            errors++;
            $display("FAIL sat_narrow: got vld=%b sum=%0d sat=%b want 1/15/1", res_valid_4, res_sum_4, res_sat_4);
        end
        checks++;
        if ({res_valid, res_sum, res_sat} !== {1'b1, 16'd21, 1'b0}) begin
            errors++;
            $display("FAIL sat_wide: got vld=%b sum=%0d sat=%b want 1/21/0", res_valid, res_sum, res_sat);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_hold_result();
        apply_reset();
        res_ready = 1'b0;
        send_beat(0, 7'h05, 1'b1);
        req_valid[1] = 1'b1;
        req_data[7 +: 7] = 7'h01;
        req_last[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, res_sum, res_id, res_sat, req_ready} !== {1'b1, 16'd2, 2'd0, 1'b0, 4'b0000}) begin
                errors++;
                $display("FAIL hold[%0d]: got vld=%b sum=%0d id=%0d sat=%b rdy=%b want 1/2/0/0/0000",
                         i, res_valid, res_sum, res_id, res_sat, req_ready);
            end
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, req_ready, res_valid, res_sum} !== '0) begin
            errors++;
            $display("FAIL gap_idle: got busy=%b rdy=%b vld=%b sum=%0d want all 0", busy, req_ready, res_valid, res_sum);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL hold_next_grant: got rdy=%b want 0010", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        req_last[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, res_sum} !== {1'b1, 2'd1, 16'd1}) begin
            errors++;
            $display("FAIL hold_second_frame: got vld=%b id=%0d sum=%0d want 1/1/1", res_valid, res_id, res_sum);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_stall();
        apply_reset();
        res_ready = 1'b1;
        send_beat(3, 7'h0F, 1'b0);
        // Stall the owner while a junk word sits on its lane and another
        // requester asks for the bus.
        req_data[3*7 +: 7] = 7'h7F;
        req_valid[0] = 1'b1;
        req_data[6:0] = 7'h7F;
        req_last[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, res_valid} !== {4'b1000, 1'b0}) begin
                errors++;
                $display("FAIL stall[%0d]: got rdy=%b vld=%b want 1000/0", i, req_ready, res_valid);
            end
            @(posedge clk);
            #1;
        end
        send_beat(3, 7'h0F, 1'b1);
        req_valid[0] = 1'b0;
        req_last[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_valid, res_sum, res_id} !== {1'b1, 16'd8, 2'd3}) begin
            errors++;
            $display("FAIL stall_result: got vld=%b sum=%0d id=%0d want 1/8/3", res_valid, res_sum, res_id);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    // Random frames on all requesters checked cycle by cycle against a
    // transaction-level model: who owns the bus, what the frame sums to.
    task automatic test_random();
        int total, done, mst, mptr, mown, msum;
        logic [N-1:0] exp_rdy;
        logic lastb;
        apply_reset();
        total = 0;
        for (int k = 0; k < N; k++) begin
            q_dat[k].delete();
            q_last[k].delete();
            for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    q_dat[k].push_back(7'($urandom));
                    q_last[k].push_back(b == len - 1);
                end
                total++;
            end
        end
        done = 0;
        mst = 0;
        mptr = 0;
        mown = 0;
        msum = 0;
        for (int c = 0; c < 4000 && done < total; c++) begin
            for (int k = 0; k < N; k++) begin
                if (q_dat[k].size() > 0) begin
                    req_valid[k] = ($urandom_range(0, 3) != 0);
                    req_data[k*7 +: 7] = q_dat[k][0];
                    req_last[k] = q_last[k][0];
                end else begin
                    req_valid[k] = 1'b0;
                    req_last[k] = 1'b0;
                end
            end
            res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_rdy = (mst == 1) ? (N'(1) << mown) : '0;
            checks++;
            if (req_ready !== exp_rdy || res_valid !== (mst == 2) || busy !== (mst != 0)) begin
                errors++;
                $display("FAIL rand_ctrl c%0d: got rdy=%b vld=%b busy=%b want rdy=%b vld=%0d busy=%0d",
                         c, req_ready, res_valid, busy, exp_rdy, mst == 2, mst != 0);
            end
            if (mst == 2) begin
                checks++;
                if (res_sum !== 16'(msum) || res_id !== 2'(mown) || res_sat !== 1'b0 ||
                    res_sum_4 !== 4'((msum > 15) ? 15 : msum) || res_sat_4 !== (msum > 15)) begin
                    errors++;
                    $display("FAIL rand_result c%0d: got sum=%0d id=%0d sat=%b sum4=%0d sat4=%b want sum=%0d id=%0d",
                             c, res_sum, res_id, res_sat, res_sum_4, res_sat_4, msum, mown);
                end
            end else begin
                checks++;
                if ({res_sum, res_id, res_sat, res_sum_4, res_sat_4} !== '0) begin
                    errors++;
                    $display("FAIL rand_idle_zero c%0d: got sum=%0d id=%0d sat=%b want 0", c, res_sum, res_id, res_sat);
                end
            end
            case (mst)
                0: if (|req_valid) begin
                    mown = rr_model(req_valid, mptr);
                    msum = 0;
                    mst = 1;
                end
                1: if (req_valid[mown]) begin
                    msum += $countones(q_dat[mown][0]);
                    lastb = q_last[mown][0];
                    void'(q_dat[mown].pop_front());
                    void'(q_last[mown].pop_front());
                    if (lastb) mst = 2;
                end
                default: if (res_ready) begin
                    done++;
                    mptr = (mown + 1) % N;
                    mst = 0;
                end
            endcase
            @(posedge clk);
            #1;
        end
        checks++;
        if (done != total) begin
            errors++;
            $display("FAIL rand_complete: got %0d frames want %0d", done, total);
        end
        req_valid = '0;
        req_last = '0;
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_single_requester();
        test_round_robin();
        test_saturation();
        test_hold_result();
        test_stall();
        test_random();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcount_frame_arbiter.md
POPCOUNT_FRAME_ARBITER -- requirements
Module: popcount_frame_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ACC_W, default 16, accumulator/result width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester beat valid.
REQ-006 SHALL have port req_data  input  7*NREQ  per-requester 7-bit word; requester k occupies bits [7k+6:7k].
REQ-007 SHALL have port req_last  input  NREQ  per-requester last-beat-of-frame flag.
REQ-008 SHALL have port req_ready  output  NREQ  per-requester beat accept; at most one bit high.
REQ-009 SHALL have port res_valid  output  1  frame result valid.
REQ-010 SHALL have port res_ready  input  1  result consumer ready.
REQ-011 SHALL have port res_sum  output  ACC_W  total count of set bits in the frame.
REQ-012 SHALL have port res_id  output  clog2(NREQ)  index of the requester that owned the frame.
REQ-013 SHALL have port res_sat  output  1  accumulator saturated during the frame.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, RESULT.
REQ-016 In IDLE with any req_valid high, SHALL select a grant by round-robin starting at index ptr, register it, clear acc and sat, and enter RUN next cycle; req_ready stays low in IDLE.
REQ-017 In RUN, SHALL drive req_ready[grant]=1 and all other bits 0; a beat transfers when req_valid[grant] and req_ready[grant] are both high.
REQ-018 Each transferred beat SHALL add popcount(word), range 0..7, to acc; if the sum exceeds 2^ACC_W-1, acc SHALL hold at all-ones and sat SHALL set.
REQ-019 Deassertion of req_valid[grant] in RUN SHALL stall without state change; other requesters SHALL be ignored until the frame ends.
REQ-020 A transfer with req_last[grant]=1 SHALL include that beat and enter RESULT next cycle; a single-beat frame is legal.
REQ-021 In RESULT, SHALL hold res_valid=1 with res_sum, res_id and res_sat stable until res_valid and res_ready are both high, then enter IDLE with ptr=(grant+1) mod NREQ.
REQ-022 Latency: res_valid SHALL rise exactly one cycle after the last-beat transfer; grant SHALL take one cycle from IDLE to RUN.
REQ-023 Minimum inter-frame gap: one IDLE cycle after the result handshake before the next RUN.
REQ-024 res_sum, res_id and res_sat SHALL read 0 whenever res_valid is 0.
REQ-025 Requests arriving during RUN or RESULT SHALL wait; none are lost, because req_ready stays low for them.

Reset
REQ-026 While rst_n is low: state=IDLE, ptr=0, acc=0, sat=0, grant=0, req_ready=0, res_valid=0, res_sum=0, res_id=0, res_sat=0, busy=0.
REQ-027 Reset asserted mid-frame or mid-result SHALL abandon the frame immediately, with no partial result emitted.

Structure
REQ-028 The state encoding enum, the default NREQ and ACC_W, and the word width 7 SHALL live in shared package popcount_pkg.
REQ-029 The 7-bit set-bit count SHALL be a combinational sub-module popcount7 (7-bit in, 3-bit out), instantiated once and muxed by grant.
REQ-030 The round-robin selection SHALL be a function inside the module; the RTL SHALL be about 150-250 lines.

Verification
REQ-031 Reset mid-RUN after 2 beats of 7'h7F -> all outputs 0 immediately; no res_valid after release.
REQ-032 Requester 2 only, beats 7'h7F, 7'h01, 7'h00(last) -> res_valid one cycle after the last beat, res_sum=8, res_id=2, res_sat=0.
REQ-033 All 4 requesters valid from reset, each sending a single beat 7'h03 with last, res_ready=1 -> grants in order 0,1,2,3, each res_sum=2.
REQ-034 ACC_W=4, 3 beats of 7'h7F -> res_sum=15, res_sat=1.
REQ-035 res_ready held low for 5 cycles in RESULT while req 1 valid -> res outputs stable, req_ready all 0; req 1 granted after the handshake.
REQ-036 req_valid[grant] toggles 1,0,0,1(last) with words 7'h0F, 7'h0F -> res_sum=8; no extra beats counted during stalls.
